// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter
//   Serialises write access from NREQ requesters into a bank of 2^AW x DW
//   flip-flop registers, with one registered read port.
//   A three-state sequencer (IDLE -> WRITE -> RELEASE) admits at most one
//   write every three cycles. The completing requester gets a one-cycle ack.
//
// Build option:
//   FF_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration; the search
//                                       starts just after the last winner.
//                          undefined -> fixed priority, lowest index wins.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  [NREQ]     per-requester write request, held until ack
//   req_addr   [NREQ*AW]  requester i address at [i*AW +: AW]
//   req_data   [NREQ*DW]  requester i data at [i*DW +: DW]
//   ack        [NREQ]     one-hot pulse: the write of requester i is done
//   rd_addr    [AW]       read address
//   rd_data    [DW]       registered read data (1-cycle latency, no bypass)
//   busy                  high while the sequencer is not idle

// One storage word of the bank.
module ff_bank_word #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (we) q <= d;
endmodule

module ff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  input  logic [AW-1:0]      rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic               busy
);
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, RELEASE = 2'd2} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  state_t  state, state_nx;
  wr_req_t lat;

  logic [NREQ-1:0][AW-1:0]  addr_v;
  logic [NREQ-1:0][DW-1:0]  data_v;
  logic [DEPTH-1:0][DW-1:0] bank_q;

  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;

  assign addr_v = req_addr;
  assign data_v = req_data;
  assign busy   = (state != IDLE);

  // ---------------- arbitration ----------------
`ifdef FF_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Scan ptr+1, ptr+2, ... wrapping; the first pending requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The pointer moves to the winner on the write edge. Reset to NREQ-1
  // gives requester 0 first priority.
  always_ff @(posedge clk or negedge reset)
    if (!reset)              rr_ptr <= IW'(NREQ - 1);
    else if (state == WRITE) rr_ptr <= lat.idx;
`else
  // Scan downward, so the lowest pending index is the last one assigned.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end
`endif

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_vld) state_nx = WRITE;
      WRITE:   state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the winner at the grant edge. Later changes to the requester's
  // address or data do not affect this write.
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      lat <= '0;
    else if (state == IDLE && grant_vld)
      lat <= '{idx: grant_idx, addr: addr_v[grant_idx], data: data_v[grant_idx]};

  always_ff @(posedge clk or negedge reset)
    if (!reset) ack <= '0;
    else begin
      ack <= '0;
      if (state == WRITE) ack[lat.idx] <= 1'b1;
    end

  // ---------------- storage and read port ----------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic we;
    assign we = (state == WRITE) && (lat.addr == AW'(g));
    ff_bank_word #(.DW(DW)) u_word (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .d     (lat.data),
      .q     (bank_q[g])
    );
  end

  // A read and a write on the same edge return the pre-write value.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd_data <= '0;
    else        rd_data <= bank_q[rd_addr];

endmodule

// File: tb/tb_ff_bank_arbiter.sv
module tb_ff_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               busy;

  always #5 clk = ~clk;

  ff_bank_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side state.
  logic          rv  [NREQ];
  logic [AW-1:0] ra  [NREQ];
  logic [DW-1:0] rdt [NREQ];

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = rv[i];
      req_addr[i*AW +: AW]   = ra[i];
      req_data[i*DW +: DW]   = rdt[i];
    end
  endtask

  // Reference model: timestamps of the last grant instead of a state
  // machine. A grant at edge L writes at L+1 (ack visible after it), is busy
  // after L and L+1, and the next grant may happen at L+3 or later.
  logic [DW-1:0]   m_bank [DEPTH];
  int              cyc, lat, lat_w, m_ptr;
  logic [AW-1:0]   lat_a;
  logic [DW-1:0]   lat_d;
  logic [NREQ-1:0] exp_ack;
  logic            exp_busy;
  logic [DW-1:0]   exp_rd;

  function automatic int pick();
    int best = -1;
    int bd   = NREQ + 1;
    int d;
    for (int i = 0; i < NREQ; i++)
      if (rv[i]) begin
`ifdef FF_ARB_ROUND_ROBIN_EN
        d = (i - m_ptr - 1 + 2 * NREQ) % NREQ;   // distance after last winner
`else
        d = i;
`endif
        if (d < bd) begin bd = d; best = i; end
      end
    return best;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
    lat      = -100;
    m_ptr    = NREQ - 1;
    exp_ack  = '0;
    exp_busy = 1'b0;
    exp_rd   = '0;
  endtask

  task automatic model_edge();
    int w;
    exp_rd = m_bank[rd_addr];
    if (cyc == lat + 1) begin
      m_bank[lat_a] = lat_d;
      m_ptr         = lat_w;
    end
    if (cyc >= lat + 3) begin
      w = pick();
      if (w >= 0) begin
        lat = cyc; lat_w = w; lat_a = ra[w]; lat_d = rdt[w];
      end
    end
    exp_ack  = (cyc == lat + 1) ? NREQ'(1 << lat_w) : '0;
    exp_busy = (cyc >= lat) && (cyc <= lat + 1);
    cyc++;
  endtask

  // One clock: inputs fixed, model advanced for the coming edge, outputs
  // checked at the following falling edge.
  task automatic tick();
    drive();
    if (reset) model_edge();
    else       model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("ack", ack, exp_ack);
    chk("busy", busy, exp_busy);
    chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic wait_ack(input string tag, input logic [NREQ-1:0] want, output int n);
    bit found = 0;
    n = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      n++;
      if (ack !== '0 || exp_ack != '0) begin
        chk(tag, ack, want);
        found = 1;
      end
    end
    if (!found) chk({tag, "_timeout"}, ack, want);
  endtask

  task automatic drop_all();
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drop_all();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic new_req(input int i);
    rv[i]  = 1'b1;
    ra[i]  = AW'($urandom_range(0, DEPTH - 1));
    rdt[i] = DW'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NREQ-1:0] want;

    reset   = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < NREQ; i++) begin rv[i] = 0; ra[i] = '0; rdt[i] = '0; end
    drive();
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd", rd_data, '0);
    reset = 1'b1;

    // Single write, then read it back.
    rv[0] = 1; ra[0] = 3'd5; rdt[0] = 8'hA5;
    wait_ack("single_ack", 4'b0001, n);
    chk("single_lat", n, 2);
    rv[0]   = 0;
    rd_addr = 3'd5;
    tick();
    chk("single_rd", rd_data, 8'hA5);

    // Read/write collision on address 3.
    rd_addr = 3'd3;
    rv[1] = 1; ra[1] = 3'd3; rdt[1] = 8'h3C;
    wait_ack("coll_ack", 4'b0010, n);
    chk("coll_old", rd_data, 8'h00);
    rv[1] = 0;
    tick();
    chk("coll_new", rd_data, 8'h3C);

    // All requesters continuously pending, from a fresh reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin rv[i] = 1; ra[i] = AW'(i); rdt[i] = DW'(8'h10 + i); end
    for (int g = 0; g < 5; g++) begin
`ifdef FF_ARB_ROUND_ROBIN_EN
      want = NREQ'(1 << (g % NREQ));
`else
      want = 4'b0001;
`endif
      wait_ack("order", want, n);
      if (g > 0) chk("spacing", n, 3);
    end
`ifndef FF_ARB_ROUND_ROBIN_EN
    // Requester 0 steps aside; the rest drain in index order.
    rv[0] = 0;
    for (int g = 1; g < NREQ; g++) begin
      wait_ack("fp_drain", NREQ'(1 << g), n);
      rv[g] = 0;
    end
`endif
    drop_all();
    repeat (3) tick();

    // Reset while the sequencer sits in WRITE: the write must never land.
    rd_addr = 3'd2;
    rv[2] = 1; ra[2] = 3'd2; rdt[2] = 8'hFF;
    n = 0;
    do begin tick(); n++; end while (!exp_busy && n < 6);
    chk("wr_busy", busy, 1'b1);
    reset = 1'b0;
    drop_all();
    drive();
    model_reset();
    #1;
    chk("async_ack", ack, '0);
    chk("async_busy", busy, 1'b0);
    chk("async_rd", rd_data, '0);
    tick();
    tick();
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      tick();
      chk("rst_sweep", rd_data, '0);
    end
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else rv[i] = 0;
        end else if (!rv[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ff_bank_arbiter.md
# ff_bank_arbiter

- Arbitrates write access to a shared bank of D flip-flop registers (2^AW words × DW bits) among NREQ requesters.
- Provides one registered read port.
- Sits between requester logic and the storage flops, and serialises writes with a three-state sequencer and a per-requester ack pulse.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width per register
- AW, 3, address width; bank depth 2^AW

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- req_valid  input  NREQ  write request per requester, level, held until ack
- req_addr  input  NREQ*AW  per-requester address, slice i = [i*AW +: AW]
- req_data  input  NREQ*DW  per-requester data, slice i = [i*DW +: DW]
- ack  output  NREQ  one-hot, one-cycle pulse: write of requester i completed
- rd_addr  input  AW  read address
- rd_data  output  DW  registered read data
- busy  output  1  high whenever FSM not in IDLE

## Operation
- Reset (reset=0, asynchronous):
  - All bank words = 0, ack = 0, rd_data = 0, busy = 0.
  - FSM = IDLE; round-robin pointer = NREQ-1, so requester 0 has first priority.
- FSM states IDLE, WRITE, RELEASE; encoding free, no other reachable states.
- IDLE:
  - If no req_valid bit is set, remain in IDLE.
  - Otherwise pick a winner per arbitration policy (see Configuration).
  - Latch the winner index, req_addr slice and req_data slice, then go to WRITE.
- WRITE:
  - Write latched data to bank[latched addr].
  - Set ack[winner]=1 and go to RELEASE.
  - Update the round-robin pointer to the winner.
- RELEASE:
  - Clear ack and go to IDLE. req_valid is ignored in this state.
- Requester contract:
  - Hold req_valid, addr and data stable until ack is seen.
  - Deassert req_valid, or present a new request, in the cycle after ack.
  - Changes to addr/data after the IDLE latch edge have no effect on the current write.
- Requests that are not granted stay pending; the bank drops nothing.
- Read port: rd_data <= bank[rd_addr] every cycle, independent of the FSM.
- No write-to-read bypass: a read sampled on the same edge as a write returns the old value.
- rd_addr and req_addr widths exactly cover the depth, so no out-of-range address exists.

## Timing
- Edge E0 (IDLE, req pending): latch winner. busy=1 after E0.
- Edge E1 (WRITE): bank updated; ack high from E1 to E2.
- Edge E2 (RELEASE): ack low, busy=0 after E2.
- Earliest next arbitration is at E3.
- Write latency: 2 edges from the latching edge to ack. Throughput: at most one write per 3 cycles.
- Read latency: 1 cycle (rd_addr sampled at edge N, rd_data valid after N).
- Reset asserted in WRITE or RELEASE: no write occurs if reset arrives before the WRITE edge. All outputs return to reset values immediately.
- A simultaneous read and write to the same address at edge E1 gives rd_data = old value; the new value is visible from the next read edge.

## Configuration
- FF_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration; search starts at pointer+1 modulo NREQ.
  - With all requesters continuously pending, grant order is 0,1,…,NREQ-1,0,…
- Not defined:
  - Fixed priority; the lowest index wins.
  - The pointer register is not built.
  - A requester held continuously pending can starve higher indices.

## Test plan
- Reset: drive reset=0 mid-run, then read all 8 addresses → rd_data=0 for each; ack=0, busy=0 throughout reset.
- Single write: req_valid=0001, addr0=5, data0=8'hA5 → ack=0001 for one cycle 2 edges after latch; then rd_addr=5 → rd_data=8'hA5 one cycle later.
- Round-robin (macro on): req_valid=1111 held, each requester writing addr=i, data=8'h10+i, and re-requesting after ack → ack order 0,1,2,3,0. Acks spaced 3 cycles apart.
- Fixed priority (macro off): req_valid=1111 with requester 0 re-requesting every time → ack always 0001. After requester 0 drops, ack order is 1,2,3.
- Reset mid-operation: assert reset while busy=1 in WRITE, before the WRITE edge, with addr=2, data=8'hFF → bank[2] stays 0 and ack never pulses.
- Read/write collision: rd_addr=3 held while writing 8'h3C to addr 3 → rd_data shows old value at the write edge and 8'h3C one cycle later.
